chunk_tail: RTL and testbench
=============================

Name: chunk_tail

Overview:
- Receiving end of the chunk-head memory-offset stream.
- Consumes one (mofs[DIM], id) beat per config id, checks that ids arrive in order beg..end-1, and linearizes each DIM-dimensional offset into a flat address: base[id] + sum(mofs[d] * pitch[id][d]).
- Emits the address, id and a last-of-chunk flag downstream over rdy/ack.
- Sits between chunk head and the DRAM/SRAM address issuer in the read pipeline.

Parameters:
- WBW, 16, width of each offset component.
- DIM, 4, number of offset dimensions.
- N_ICFG, 4, number of input configs.
- ABW, 32, output address width.
- ICFG_BW, $clog2(N_ICFG+1), id/beg/end width (derived).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_mofs_rdy  in  1  source has a beat.
- i_mofs_ack  out  1  beat accepted this cycle.
- i_mofs  in  WBW x DIM  offsets.
- i_id  in  ICFG_BW  config id of beat.
- i_beg  in  ICFG_BW  first id of chunk (static during chunk).
- i_end  in  ICFG_BW  one-past-last id (static during chunk).
- i_base  in  ABW x N_ICFG  per-config base address.
- i_pitch  in  ABW x N_ICFG x DIM  per-config per-dim pitch.
- o_addr_rdy  out  1  output valid.
- o_addr_ack  in  1  sink accepts (only when o_addr_rdy).
- o_addr  out  ABW  linear address.
- o_id  out  ICFG_BW  id of address.
- o_last  out  1  beat is last id of chunk.
- o_err  out  1  sticky id-order error.

Behaviour:
- Handshake:
  - Transfer on a port happens when rdy && ack.
  - i_mofs_ack = i_mofs_rdy && (s1 empty || s1 advancing).
  - A source never drops rdy before ack; the block does not rely on that, but asserts ack only with rdy.
- Pipeline: two register stages, S1 and S2, each with a valid bit.
  - S1 latches i_mofs, i_id, and last = (i_id+1 == i_end). It also latches per-dim products mofs[d]*pitch[id][d], zero-extended, truncated to ABW.
  - S2 latches base[id] + sum of S1 products, mod 2^ABW, plus id and last.
  - o_addr/o_id/o_last are driven from S2; o_addr_rdy = S2 valid.
  - S1 advances when S2 is empty or o_addr_ack.
  - S2 clears on ack unless S1 refills it in the same cycle.
  - Latency: input transfer in cycle t gives o_addr_rdy at t+2 when not stalled.
  - Throughput: 1 beat/cycle under continuous ack.
- Stall: with o_addr_ack low, both stages fill, then i_mofs_ack drops. No beat is lost or duplicated. S2 outputs are held stable while rdy && !ack.
- Order check:
  - Register exp_id starts at i_beg.
  - On each accepted input: if i_id != exp_id, set o_err (sticky until reset).
  - Then exp_id <= (i_id+1 == i_end) ? i_beg : i_id+1, so it resyncs to the received id.
  - exp_id wraps to i_beg after the last id, ready for the next chunk.
- Single-config chunk (i_end == i_beg+1): every beat has o_last=1.
- Simultaneous output ack and input accept with both stages full: S2 takes S1, S1 takes the new beat in the same cycle.
- Reset (any cycle, including mid-stream):
  - o_addr_rdy=0, i_mofs_ack=0, o_addr=0, o_id=0, o_last=0, o_err=0.
  - Valid bits 0, exp_id loads i_beg on the first cycle after reset.
  - In-flight beats are discarded.
- Arithmetic:
  - All unsigned. Products are WBW x ABW, truncated to ABW.
  - Sum wraps mod 2^ABW; no overflow flag.
- Ids >= N_ICFG are out of contract. They index base/pitch with the value clamped to N_ICFG-1 and set o_err.

Test Plan:
- beg=0,end=3, base={0x1000,0x2000,0x3000}, pitch[id]={1,16,256,4096}, mofs={1,2,3,0} ids 0,1,2 with ack always 1 -> o_addr 0x1321,0x2321,0x3321 at cycles t+2..t+4, o_last only on id 2, o_err=0.
- Same stream, o_addr_ack held 0 for 5 cycles -> i_mofs_ack drops after 2 beats, o_addr=0x1321 stable; after release, 3 outputs in order, none lost.
- ids 0,2,1 with beg=0,end=3 -> o_err rises on the cycle after the id-2 accept and stays 1.
- beg=2,end=3 with three beats of id 2 -> each o_last=1, o_err=0.
- Pitch 0xFFFFFFFF, mofs[0]=2, base=4 -> o_addr=0x00000002 (wrap).
- i_rst pulse with both stages full -> next cycle o_addr_rdy=0, o_err=0. A fresh id-beg beat is accepted without error and appears 2 cycles later.

Source files
------------

// File: rtl/chunk_tail.sv
// Receiving end of the chunk-head offset stream: checks id order and turns each
// DIM-dimensional offset into a flat address through a two-stage pipeline.
module chunk_tail #(
  parameter int WBW     = 16,
  parameter int DIM     = 4,
  parameter int N_ICFG  = 4,
  parameter int ABW     = 32,
  parameter int ICFG_BW = $clog2(N_ICFG + 1)
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_mofs_rdy,
  output logic                               i_mofs_ack,
  input  logic [DIM-1:0][WBW-1:0]            i_mofs,
  input  logic [ICFG_BW-1:0]                 i_id,
  input  logic [ICFG_BW-1:0]                 i_beg,
  input  logic [ICFG_BW-1:0]                 i_end,
  input  logic [N_ICFG-1:0][ABW-1:0]         i_base,
  input  logic [N_ICFG-1:0][DIM-1:0][ABW-1:0] i_pitch,
  output logic                               o_addr_rdy,
  input  logic                               o_addr_ack,
  output logic [ABW-1:0]                     o_addr,
  output logic [ICFG_BW-1:0]                 o_id,
  output logic                               o_last,
  output logic                               o_err
);

  localparam int IDX_BW = (N_ICFG > 1) ? $clog2(N_ICFG) : 1;
  localparam logic [ICFG_BW:0] ONE_X = 1;

  function automatic logic [ABW-1:0] mul_trunc(input logic [WBW-1:0] m,
                                               input logic [ABW-1:0] p);
    logic [ABW-1:0] mx;
    mx = ABW'(m);
    return mx * p;
  endfunction

  function automatic logic [ABW-1:0] add_wrap(input logic [ABW-1:0] base,
                                              input logic [DIM-1:0][ABW-1:0] prods);
    logic [ABW-1:0] acc;
    acc = base;
    for (int d = 0; d < DIM; d++) begin
      acc = acc + prods[d];
    end
    return acc;
  endfunction

  logic                      r_vld_p1;
  logic                      r_vld_p2;
  logic [DIM-1:0][ABW-1:0]   r_prod_p1;
  logic [ICFG_BW-1:0]        r_id_p1;
  logic [IDX_BW-1:0]         r_idx_p1;
  logic                      r_last_p1;
  logic [ABW-1:0]            r_addr_p2;
  logic [ICFG_BW-1:0]        r_id_p2;
  logic                      r_last_p2;
  logic                      r_err;
  logic                      r_sync;
  logic [ICFG_BW-1:0]        r_exp_id;

  logic                      w_adv_p1;
  logic                      w_ld_p1;
  logic                      w_acc;
  logic                      w_oor;
  logic [IDX_BW-1:0]         w_idx;
  logic [ICFG_BW:0]          w_id_x;
  logic                      w_last;
  logic [ICFG_BW-1:0]        w_exp;
  logic [DIM-1:0][ABW-1:0]   w_prod;

  assign w_adv_p1   = !r_vld_p2 || o_addr_ack;
  assign w_ld_p1    = !r_vld_p1 || w_adv_p1;
  assign w_acc      = i_mofs_rdy && w_ld_p1 && !i_rst;
  assign i_mofs_ack = w_acc;

  // Out-of-range ids borrow the last config's base/pitch and are flagged as errors.
  assign w_oor  = (i_id >= ICFG_BW'(N_ICFG));
  assign w_idx  = w_oor ? IDX_BW'(N_ICFG - 1) : i_id[IDX_BW-1:0];
  assign w_id_x = {1'b0, i_id} + ONE_X;
  assign w_last = (w_id_x == {1'b0, i_end});
  assign w_exp  = r_sync ? i_beg : r_exp_id;

  always_comb begin
    w_prod = '0;
    for (int d = 0; d < DIM; d++) begin
      w_prod[d] = mul_trunc(i_mofs[d], i_pitch[w_idx][d]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_err    <= 1'b0;
      r_sync   <= 1'b1;
      r_exp_id <= i_beg;
    end else begin
      if (w_ld_p1) r_vld_p1 <= w_acc;
      if (w_adv_p1) r_vld_p2 <= r_vld_p1;
      if (w_acc) begin
        if (i_id != w_exp || w_oor) r_err <= 1'b1;
        r_exp_id <= w_last ? i_beg : w_id_x[ICFG_BW-1:0];
        r_sync   <= 1'b0;
      end
    end
  end

  // Stage p1: per-dimension products, id and last flag
  always_ff @(posedge i_clk) begin
    if (w_acc) begin
      r_prod_p1 <= w_prod;
      r_id_p1   <= i_id;
      r_idx_p1  <= w_idx;
      r_last_p1 <= w_last;
    end
  end

  // Stage p2: base plus product sum, wrapping at the address width
  always_ff @(posedge i_clk) begin
    if (w_adv_p1 && r_vld_p1) begin
      r_addr_p2 <= add_wrap(i_base[r_idx_p1], r_prod_p1);
      r_id_p2   <= r_id_p1;
      r_last_p2 <= r_last_p1;
    end
  end

  assign o_addr_rdy = r_vld_p2;
  assign o_addr     = r_vld_p2 ? r_addr_p2 : '0;
  assign o_id       = r_vld_p2 ? r_id_p2 : '0;
  assign o_last     = r_vld_p2 && r_last_p2;
  assign o_err      = r_err;

endmodule

// File: tb/tb_chunk_tail.sv
// Randomised and directed bench for chunk_tail against a transaction-level model.
module tb_chunk_tail;
  localparam int WBW = 16, DIM = 4, N_ICFG = 4, ABW = 32, ICFG_BW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, mofs_rdy, mofs_ack, addr_rdy, addr_ack, last, err;
  logic [DIM-1:0][WBW-1:0]             mofs;
  logic [ICFG_BW-1:0]                  id, beg, end_, o_id;
  logic [N_ICFG-1:0][ABW-1:0]          base;
  logic [N_ICFG-1:0][DIM-1:0][ABW-1:0] pitch;
  logic [ABW-1:0]                      addr;

  chunk_tail #(.WBW(WBW), .DIM(DIM), .N_ICFG(N_ICFG), .ABW(ABW)) dut (
    .i_clk(clk), .i_rst(rst), .i_mofs_rdy(mofs_rdy), .i_mofs_ack(mofs_ack),
    .i_mofs(mofs), .i_id(id), .i_beg(beg), .i_end(end_), .i_base(base),
    .i_pitch(pitch), .o_addr_rdy(addr_rdy), .o_addr_ack(addr_ack),
    .o_addr(addr), .o_id(o_id), .o_last(last), .o_err(err)
  );

  typedef struct {logic [ABW-1:0] addr; int id; bit last; int e;} ent_t;
  ent_t           q[$];
  logic [ABW-1:0] seen_addr[$];
  bit             seen_last[$];
  int  total = 0, bad = 0, ncyc = 0, exp_id = 0;
  bit  err_m = 1'b0, last_in = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  function automatic logic [ABW-1:0] ref_addr(input int idv, input logic [DIM-1:0][WBW-1:0] m);
    int k;
    longint unsigned acc;
    k = (idv >= N_ICFG) ? N_ICFG - 1 : idv;
    acc = 64'(base[k]);
    for (int d = 0; d < DIM; d++) acc += 64'(m[d]) * 64'(pitch[k][d]);
    return acc[ABW-1:0];
  endfunction

  function automatic logic [DIM-1:0][WBW-1:0] mk(input int a, input int b, input int c, input int d);
    logic [DIM-1:0][WBW-1:0] r;
    r[0] = WBW'(a); r[1] = WBW'(b); r[2] = WBW'(c); r[3] = WBW'(d);
    return r;
  endfunction

  // One clock: check at the falling edge, advance the model after the rising edge.
  task automatic cyc();
    bit in_x, out_x, l_obs;
    logic [ABW-1:0] a_obs;
    ent_t e;
    int idv;
    @(negedge clk);
    in_x  = mofs_rdy && mofs_ack;
    out_x = addr_rdy && addr_ack;
    a_obs = addr;
    l_obs = last;
    chk("in_ack", 64'(mofs_ack), 64'(!rst && mofs_rdy && (q.size() < 2 || addr_ack)));
    if (!rst) begin
      chk("out_rdy", 64'(addr_rdy), 64'(q.size() > 0 && ncyc >= q[0].e + 1));
      chk("err", 64'(err), 64'(err_m));
      if (addr_rdy && q.size() > 0) begin
        chk("addr", 64'(addr), 64'(q[0].addr));
        chk("id", 64'(o_id), 64'(q[0].id));
        chk("last", 64'(last), 64'(q[0].last));
      end
    end
    @(posedge clk);
    ncyc++;
    last_in = 1'b0;
    if (rst) begin
      q.delete();
      err_m  = 1'b0;
      exp_id = int'(beg);
    end else begin
      if (out_x && q.size() > 0) begin
        void'(q.pop_front());
        seen_addr.push_back(a_obs);
        seen_last.push_back(l_obs);
      end
      if (in_x) begin
        idv    = int'(id);
        e.addr = ref_addr(idv, mofs);
        e.id   = idv;
        e.last = (idv + 1 == int'(end_));
        e.e    = ncyc;
        q.push_back(e);
        if (idv != exp_id || idv >= N_ICFG) err_m = 1'b1;
        exp_id  = e.last ? int'(beg) : idv + 1;
        last_in = 1'b1;
      end
    end
    #1;
  endtask

  task automatic send(input int idv, input logic [DIM-1:0][WBW-1:0] m);
    int n;
    n = 0;
    mofs_rdy = 1'b1;
    id       = ICFG_BW'(idv);
    mofs     = m;
    do begin
      cyc();
      n++;
    end while (!last_in && n < 50);
    chk("send_done", 64'(last_in), 64'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    mofs_rdy = 1'b0;
    addr_ack = 1'b1;
    while (q.size() > 0 && n < 40) begin
      cyc();
      n++;
    end
    cyc();
    chk("drain_empty", 64'(q.size()), 64'(0));
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    mofs_rdy = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic std_cfg();
    beg  = 3'd0;
    end_ = 3'd3;
    for (int i = 0; i < N_ICFG; i++) begin
      base[i] = ABW'((i + 1) * 32'h1000);
      for (int d = 0; d < DIM; d++) pitch[i][d] = ABW'(1) << (4 * d);
    end
  endtask

  logic [DIM-1:0][WBW-1:0] m0;
  int idx, nid, idv, nb;
  bit pend;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at cycle %0d", ncyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mofs_rdy = 1'b0; addr_ack = 1'b0;
    mofs = '0; id = '0; base = '0; pitch = '0;
    std_cfg();
    m0 = mk(1, 2, 3, 0);
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_rdy", 64'(addr_rdy), 64'(0));
    chk("rst_addr", 64'(addr), 64'(0));
    chk("rst_id", 64'(o_id), 64'(0));
    chk("rst_last", 64'(last), 64'(0));
    chk("rst_err", 64'(err), 64'(0));

    // basic stream with continuous ack
    addr_ack = 1'b1;
    seen_addr.delete(); seen_last.delete();
    send(0, m0); send(1, m0); send(2, m0);
    drain();
    chk("t1_n", 64'(seen_addr.size()), 64'(3));
    chk("t1_a0", 64'(seen_addr[0]), 64'h1321);
    chk("t1_a1", 64'(seen_addr[1]), 64'h2321);
    chk("t1_a2", 64'(seen_addr[2]), 64'h3321);
    chk("t1_l0", 64'(seen_last[0]), 64'(0));
    chk("t1_l2", 64'(seen_last[2]), 64'(1));
    chk("t1_err", 64'(err), 64'(0));

    // output stall for five cycles
    seen_addr.delete(); seen_last.delete();
    addr_ack = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      mofs_rdy = 1'b1; id = ICFG_BW'(idx); mofs = m0;
      cyc();
      if (last_in) idx++;
    end
    chk("stall_acc", 64'(idx), 64'(2));
    chk("stall_hold", 64'(addr), 64'h1321);
    addr_ack = 1'b1;
    while (idx < 3) begin
      send(idx, m0);
      idx++;
    end
    drain();
    chk("t2_n", 64'(seen_addr.size()), 64'(3));
    chk("t2_a0", 64'(seen_addr[0]), 64'h1321);
    chk("t2_a1", 64'(seen_addr[1]), 64'h2321);
    chk("t2_a2", 64'(seen_addr[2]), 64'h3321);

    // out-of-order ids
    send(0, m0); send(2, m0); send(1, m0);
    drain();
    chk("t3_err", 64'(err), 64'(1));
    do_reset();
    chk("t3_clr", 64'(err), 64'(0));

    // single-config chunk
    beg = 3'd2;
    do_reset();
    seen_addr.delete(); seen_last.delete();
    send(2, m0); send(2, m0); send(2, m0);
    drain();
    chk("t4_n", 64'(seen_last.size()), 64'(3));
    for (int i = 0; i < 3; i++) chk("t4_last", 64'(seen_last[i]), 64'(1));
    chk("t4_err", 64'(err), 64'(0));

    // address wrap
    beg = 3'd0; end_ = 3'd1;
    base[0] = 32'd4; pitch[0][0] = 32'hFFFF_FFFF;
    do_reset();
    seen_addr.delete(); seen_last.delete();
    send(0, mk(2, 0, 0, 0));
    drain();
    chk("t5_wrap", 64'(seen_addr[0]), 64'h2);

    // reset with both stages full and the error flag set
    std_cfg();
    do_reset();
    addr_ack = 1'b0;
    send(1, m0); send(2, m0);
    mofs_rdy = 1'b0;
    cyc();
    chk("t6_full_err", 64'(err), 64'(1));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_rdy", 64'(addr_rdy), 64'(0));
    chk("t6_err", 64'(err), 64'(0));
    chk("t6_addr", 64'(addr), 64'(0));
    addr_ack = 1'b1;
    seen_addr.delete(); seen_last.delete();
    send(0, m0);
    drain();
    chk("t6_n", 64'(seen_addr.size()), 64'(1));
    chk("t6_a", 64'(seen_addr[0]), 64'h1321);
    chk("t6_err2", 64'(err), 64'(0));

    // randomised traffic with random configs and stalls
    for (int r = 0; r < 6; r++) begin
      beg  = ICFG_BW'($urandom_range(0, 3));
      end_ = ICFG_BW'($urandom_range(int'(beg) + 1, 4));
      for (int i = 0; i < N_ICFG; i++) begin
        base[i] = $urandom;
        for (int d = 0; d < DIM; d++)
          pitch[i][d] = ($urandom_range(0, 3) == 0) ? $urandom : ABW'($urandom_range(0, 4095));
      end
      do_reset();
      nid = int'(beg); nb = 0; pend = 1'b0; idv = 0;
      for (int k = 0; k < 300 && nb < 50; k++) begin
        addr_ack = ($urandom_range(0, 9) < 7);
        if (!pend) begin
          idv  = ($urandom_range(0, 19) < 19 - r) ? nid : int'($urandom_range(0, 7));
          m0   = mk(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                    int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
          pend = 1'b1;
        end
        mofs_rdy = ($urandom_range(0, 9) < 8);
        id   = ICFG_BW'(idv);
        mofs = m0;
        cyc();
        if (last_in) begin
          pend = 1'b0;
          nb++;
          nid = (idv + 1 == int'(end_)) ? int'(beg) : idv + 1;
          if (nid >= 8) nid = int'(beg);
        end
      end
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
